// File: rtl/rom_burst_reader.sv
// rom_burst_reader: multi-bank ROM burst reader with a 2-entry skid buffer on a valid/ready stream
module rom_burst_reader #(
  parameter int ADDR_WIDTH = 3,
  parameter int WORD_SIZE = 8,
  parameter int NUM_BANKS = 1,
  parameter logic [NUM_BANKS*(2**ADDR_WIDTH)*WORD_SIZE-1:0] INIT_DATA = '0
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]          cmd_addr_i,
  input  logic [ADDR_WIDTH-1:0]          cmd_len_i,
  output logic                           data_valid_o,
  input  logic                           data_ready_i,
  output logic [NUM_BANKS*WORD_SIZE-1:0] data_o,
  output logic                           last_o,
  output logic                           busy_o
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int DW = NUM_BANKS*WORD_SIZE;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] rd_addr, remaining;
  logic [WORD_SIZE-1:0] rom [NUM_BANKS][DEPTH];
  logic [DW-1:0] rom_word, rom_q;
  logic rom_last, inflight, pop, issue;
  logic [DW:0] buf0, buf1;
  logic [1:0] occ, used;
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
      assign rom[b][i] = INIT_DATA[(b*DEPTH+i)*WORD_SIZE +: WORD_SIZE];
    end
    assign rom_word[b*WORD_SIZE +: WORD_SIZE] = rom[b][rd_addr];
  end
  always_comb begin
    data_valid_o = occ != 2'd0;
    data_o = buf0[DW-1:0];
    last_o = data_valid_o && buf0[DW];
    pop = data_valid_o && data_ready_i;
    used = occ + {1'b0, inflight};
    issue = state == READ && (used < 2'd2 || (used == 2'd2 && pop));
  end
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state <= IDLE;
      cmd_ready_o <= 1'b1;
      busy_o <= 1'b0;
      rd_addr <= '0;
      remaining <= '0;
    end else
      case (state)
        IDLE:
          if (cmd_valid_i) begin
            state <= READ;
            cmd_ready_o <= 1'b0;
            busy_o <= 1'b1;
            rd_addr <= cmd_addr_i;
            remaining <= cmd_len_i;
          end
        READ:
          if (issue) begin
            rd_addr <= rd_addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == '0) state <= DRAIN;
          end
        DRAIN:
          if (pop && buf0[DW]) begin
            state <= IDLE;
            cmd_ready_o <= 1'b1;
            busy_o <= 1'b0;
          end
        default: state <= IDLE;
      endcase
  always_ff @(posedge clk_i)
    if (reset_i) begin
      rom_q <= '0;
      rom_last <= 1'b0;
      inflight <= 1'b0;
      occ <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rom_q <= rom_word;
        rom_last <= remaining == '0;
      end
      if (inflight && (occ == 2'd0 || (occ == 2'd1 && pop))) buf0 <= {rom_last, rom_q};
      else if (pop) buf0 <= buf1;
      if (inflight && ((occ == 2'd1 && !pop) || occ == 2'd2)) buf1 <= {rom_last, rom_q};
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
      assert (!(inflight && !pop && occ == 2'd2));
    end
endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: directed and randomized bursts checked against a queue-based beat model
module tb_rom_burst_reader;
  logic clk = 1'b0, reset = 1'b0, cmd_valid = 1'b0, data_ready = 1'b0;
  logic [2:0] cmd_addr = 3'd0, cmd_len = 3'd0;
  logic cmd_ready, data_valid, last, busy;
  logic [23:0] data;
  int errors = 0, checks = 0;
  logic [24:0] exp_q[$];
  logic mbusy = 1'b0, stall_hold = 1'b0;
  logic [24:0] held = '0;
  logic [5:0] bp = 6'b101001;
  function automatic logic [7:0] rom_val(input int b, input int i);
    return (b == 0 && i == 5) ? 8'hA5 : 8'(16*b+i);
  endfunction
  function automatic logic [191:0] build_init();
    logic [191:0] v = '0;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 8; i++) v[(b*8+i)*8 +: 8] = rom_val(b, i);
    return v;
  endfunction
  function automatic logic [23:0] beat(input logic [2:0] a);
    return {rom_val(2, int'(a)), rom_val(1, int'(a)), rom_val(0, int'(a))};
  endfunction
  localparam logic [191:0] INIT = build_init();
  rom_burst_reader #(.ADDR_WIDTH(3), .WORD_SIZE(8), .NUM_BANKS(3), .INIT_DATA(INIT)) dut (
    .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .data_valid_o(data_valid),
    .data_ready_i(data_ready), .data_o(data), .last_o(last), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input int a, input int l);
    cmd_addr = 3'(a);
    cmd_len = 3'(l);
    cmd_valid = 1'b1;
  endtask
  task automatic tick();
    logic [24:0] e;
    logic acc, nb;
    nb = mbusy;
    if (stall_hold) begin
      chk("stall_valid", 32'(data_valid), 32'(1'b1));
      chk("stall_beat", 32'({last, data}), 32'(held));
    end
    chk("busy", 32'(busy), 32'(mbusy));
    chk("cmd_ready", 32'(cmd_ready), 32'(!mbusy));
    if (data_valid && data_ready) begin
      e = '1;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      chk("beat", 32'({last, data}), 32'(e));
      if (e[24]) nb = 1'b0;
    end
    stall_hold = data_valid && !data_ready;
    held = {last, data};
    acc = cmd_valid && cmd_ready;
    if (acc) begin
      for (int k = 0; k <= int'(cmd_len); k++)
        exp_q.push_back({k == int'(cmd_len), beat(3'(int'(cmd_addr) + k))});
      nb = 1'b1;
    end
    @(posedge clk);
    #1;
    mbusy = nb;
    if (acc) cmd_valid = 1'b0;
  endtask
  task automatic wait_idle(input int mode);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || mbusy || cmd_valid); i++) begin
      data_ready = mode == 0 ? 1'b1 : mode == 1 ? bp[i % 6] : ($urandom_range(0, 3) != 0);
      tick();
    end
    chk("drain_left", 32'(exp_q.size()), 0);
    chk("drain_cmd", 32'(cmd_valid), 0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    mbusy = 1'b0;
    stall_hold = 1'b0;
  endtask
  initial begin
    do_reset();
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_data", 32'(data), 0);
    chk("rst_last", 32'(last), 0);
    data_ready = 1'b1;
    send(5, 0);
    tick();
    chk("lat_t1", 32'(data_valid), 0);
    tick();
    chk("lat_t2", 32'(data_valid), 0);
    tick();
    chk("lat_t3", 32'(data_valid), 1);
    chk("single_data", 32'(data), 32'h2515A5);
    chk("single_last", 32'(last), 1);
    tick();
    tick();
    chk("single_busy", 32'(busy), 0);
    send(0, 7);
    tick();
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("full_consec", 32'(data_valid), 1);
      tick();
    end
    wait_idle(0);
    send(6, 3);
    wait_idle(0);
    send(0, 7);
    wait_idle(1);
    data_ready = 1'b1;
    send(2, 1);
    tick();
    tick();
    tick();
    chk("mb_beat0", 32'({last, data}), 32'h0221202);
    tick();
    chk("mb_beat1", 32'({last, data}), 32'h1231303);
    wait_idle(0);
    send(1, 4);
    tick();
    send(3, 2);
    tick();
    tick();
    chk("holdoff_ready", 32'(cmd_ready), 0);
    chk("holdoff_pending", 32'(cmd_valid), 1);
    wait_idle(0);
    send(0, 7);
    data_ready = 1'b0;
    repeat (5) tick();
    do_reset();
    chk("mid_valid", 32'(data_valid), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_ready", 32'(cmd_ready), 1);
    data_ready = 1'b1;
    repeat (4) tick();
    send(4, 2);
    wait_idle(2);
    for (int n = 0; n < 25; n++) begin
      send(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      wait_idle(2);
      repeat ($urandom_range(0, 2)) tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
